// File: rtl/jump_encoder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jump_encoder_pkg                                                 |
// | Shared MIPS constants: J/JAL opcodes, FSM states, result record. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package jump_encoder_pkg;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

    typedef struct packed {
        logic [31:0] instr;
        logic        err_align;
        logic        err_region;
    } jump_result_t;

endpackage
`default_nettype wire

// File: rtl/jump_field_pack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jump_field_pack                                                  |
// | Pure J-format packing: opcode select, index extraction, checks.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module jump_field_pack
    import jump_encoder_pkg::*;
(
    input  logic [31:0]  target_addr,
    input  logic [3:0]   pc_region,
    input  logic         link,
    output jump_result_t result
);

    // The index drops the byte offset and the region nibble; both are
    // reported through the flags rather than blocking the encode.
    always_comb begin
        result.instr      = {(link ? OP_JAL : OP_J), target_addr[27:2]};
        result.err_align  = |target_addr[1:0];
        result.err_region = (target_addr[31:28] != pc_region);
    end

endmodule
`default_nettype wire

// File: rtl/jump_encoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jump_encoder                                                     |
// | One-entry output buffer for encoded J/JAL words, error counter.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module jump_encoder
    import jump_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] target_addr,
    input  logic [31:0] pc_plus4,
    input  logic        link,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err_align,
    output logic        err_region,
    output logic [7:0]  err_count
);

    logic [0:0]   state_q, state_d;
    jump_result_t result_q, result_d;
    logic [7:0]   err_count_q, err_count_d;
    jump_result_t packed_result;
    logic         accept;
    logic         unused_pc_bits;

    // Only the region nibble of the next-PC matters.
    assign unused_pc_bits = ^pc_plus4[27:0];

    jump_field_pack u_field_pack (
        .target_addr (target_addr),
        .pc_region   (pc_plus4[31:28]),
        .link        (link),
        .result      (packed_result)
    );

    assign out_valid  = (state_q == ST_FULL);
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;

    assign instr      = result_q.instr;
    assign err_align  = result_q.err_align;
    assign err_region = result_q.err_region;
    assign err_count  = err_count_q;

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        err_count_d = err_count_q;
        if (accept) begin
            state_d  = ST_FULL;
            result_d = packed_result;
            if ((packed_result.err_align || packed_result.err_region) &&
                (err_count_q != ERR_COUNT_MAX)) begin
                err_count_d = err_count_q + 8'd1;
            end
        end else if (out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            result_q    <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            err_count_q <= err_count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jump_encoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_jump_encoder                                                  |
// | Scoreboard bench: random and directed jumps vs. reference model. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_jump_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] target_addr;
    logic [31:0] pc_plus4;
    logic        link;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err_align;
    logic        err_region;
    logic [7:0]  err_count;

    jump_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .target_addr (target_addr),
        .pc_plus4    (pc_plus4),
        .link        (link),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instr       (instr),
        .err_align   (err_align),
        .err_region  (err_region),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        al;
        logic        rg;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    bit   model_full = 1'b0;
    int   model_cnt  = 0;
    int   n_pass = 0, n_total = 0, n_push = 0, n_pop = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference: applies the handshake rules at each rising edge.
    task automatic model_edge();
        exp_t e;
        int   op;
        bit   ok;
        ok = !model_full || out_ready;
        if (in_valid && ok) begin
            op      = link ? 3 : 2;
            e.instr = (32'(op) << 26) | ((target_addr >> 2) & 32'h03FF_FFFF);
            e.al    = (target_addr % 4) != 0;
            e.rg    = (target_addr >> 28) != (pc_plus4 >> 28);
            if ((e.al || e.rg) && model_cnt < 255) model_cnt++;
            e.cnt   = 8'(model_cnt);
            sb.push_back(e);
            n_push++;
            model_full = 1'b1;
        end else if (out_ready) begin
            model_full = 1'b0;
        end
    endtask

    task automatic step(bit iv, logic [31:0] t, logic [31:0] pc, bit lk, bit ordy);
        in_valid    = iv;
        target_addr = t;
        pc_plus4    = pc;
        link        = lk;
        out_ready   = ordy;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: compares held result against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready", 32'(in_ready), 32'(!model_full || out_ready));
            check("out_valid", 32'(out_valid), 32'(model_full));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_empty: got out_valid=1, expected no pending result at %0t", $time);
                end else begin
                    check("sb_instr", instr, sb[0].instr);
                    check("sb_err_align", 32'(err_align), 32'(sb[0].al));
                    check("sb_err_region", 32'(err_region), 32'(sb[0].rg));
                    check("sb_err_count", 32'(err_count), 32'(sb[0].cnt));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        n_pop++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held;
        logic [31:0] pc;
        logic [31:0] t;
        reset = 1'b1; in_valid = 1'b0; target_addr = '0; pc_plus4 = '0;
        link = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_flags", 32'({err_align, err_region}), 32'd0);
        #5 reset = 1'b0;
        @(posedge clk); #1;

        pc = 32'h0040_0004;
        step(1, 32'h0040_0020, pc, 0, 1);
        check("j_basic_valid", 32'(out_valid), 32'd1);
        check("j_basic_instr", instr, 32'h0810_0008);
        check("j_basic_flags", 32'({err_align, err_region}), 32'd0);
        step(1, 32'h0040_0020, pc, 1, 1);
        check("jal_instr", instr, 32'h0C10_0008);
        step(1, 32'h0040_0022, pc, 0, 1);
        check("align_instr", instr, 32'h0810_0008);
        check("align_flag", 32'(err_align), 32'd1);
        check("align_count", 32'(err_count), 32'd1);
        step(1, 32'h1000_0000, pc, 0, 1);
        check("region_instr", instr, 32'h0800_0000);
        check("region_flag", 32'({err_align, err_region}), 32'd1);
        step(0, 0, pc, 0, 1);

        // Back-pressure: result must hold while the consumer stalls.
        step(1, 32'h0040_0100, pc, 0, 1);
        held = instr;
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h0040_0200, pc, 1, 0);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_instr", instr, held);
        end
        step(1, 32'h0040_0200, pc, 1, 1);
        check("swap_instr", instr, 32'h0C10_0080);
        step(0, 0, pc, 0, 1);
        check("drain_empty", 32'(sb.size()), 32'd0);

        for (int i = 0; i < 300; i++) begin
            pc = $urandom;
            t  = ($urandom_range(0, 2) != 0) ? {pc[31:28], 28'($urandom)} : $urandom;
            if ($urandom_range(0, 1) == 1) t[1:0] = 2'b00;
            step(1'($urandom_range(0, 3) != 0), t, pc, 1'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        step(0, 0, pc, 0, 1);

        for (int i = 0; i < 260; i++) begin
            step(1, $urandom | 32'h1, $urandom, 1'($urandom), 1);
        end
        check("sat_count", 32'(err_count), 32'hFF);
        step(0, 0, pc, 0, 1);

        // Asynchronous reset while a result is held.
        step(1, 32'h0040_0020, 32'h0040_0004, 0, 0);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        check("mid_rst_instr", instr, 32'h0);
        sb.delete();
        model_full = 1'b0;
        model_cnt  = 0;
        #3 reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        step(1, 32'h0040_0022, 32'h0040_0004, 0, 1);
        check("post_rst_count", 32'(err_count), 32'd1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        check("final_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jump_encoder.md
JUMP_ENCODER -- requirements
Module: jump_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: request present.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a request this cycle.
REQ-005 SHALL have port target_addr, input, 32 bits: jump target byte address.
REQ-006 SHALL have port pc_plus4, input, 32 bits: address of the delay/next instruction, used for the region check.
REQ-007 SHALL have port link, input, 1 bit: 1 selects JAL (opcode 6'b000011), 0 selects J (opcode 6'b000010).
REQ-008 SHALL have port out_valid, output, 1 bit: encoded instruction held.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the held result.
REQ-010 SHALL have port instr, output, 32 bits: encoded J-format word {opcode, index[25:0]}.
REQ-011 SHALL have port err_align, output, 1 bit: target_addr[1:0] was nonzero.
REQ-012 SHALL have port err_region, output, 1 bit: target_addr[31:28] differed from pc_plus4[31:28].
REQ-013 SHALL have port err_count, output, 8 bits: saturating count of accepted requests with any error.

Function
REQ-014 SHALL encode in the inverse direction of the jump-target shift: index = target_addr[27:2], the bits that a left shift by 2 and concatenation with pc_plus4[31:28] would restore.
REQ-015 SHALL accept a request when in_valid and in_ready are both 1 (the accept cycle).
REQ-016 SHALL register instr, err_align, and err_region on the accept edge and assert out_valid the following cycle, giving a latency of 1 cycle.
REQ-017 SHALL drive in_ready = !out_valid || out_ready, so a new request is accepted in the same cycle the old result is consumed (throughput of 1 per cycle).
REQ-018 SHALL use a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
- EMPTY to FULL on accept.
- FULL to EMPTY on out_ready without accept.
- FULL to FULL on simultaneous out_ready and accept, with the output replaced by the new result.
REQ-019 SHALL hold instr and the error flags stable while out_valid=1 and out_ready=0; inputs SHALL be ignored in that state.
REQ-020 SHALL still emit the encoded word on error (index truncated as per REQ-014), with the flags qualifying it; err_align and err_region may both be 1.
REQ-021 SHALL increment err_count by 1 on each accept where either error is true, saturating at 8'hFF.
REQ-022 SHALL make the flags and instr meaningful only while out_valid=1.

Reset
REQ-023 SHALL on reset force state EMPTY, out_valid=0, instr=32'h0, err_align=0, err_region=0, err_count=0, immediately and asynchronously.
REQ-024 SHALL discard a held result on reset asserted mid-operation; in_ready SHALL read 1 from the first cycle after deassertion.

Structure
REQ-025 SHALL place the opcode constants OP_J=6'b000010 and OP_JAL=6'b000011 and the FSM state encoding in the shared MIPS package.
REQ-026 SHALL implement the pure encoding and checks (index extraction, opcode select, error flags) as sub-module jump_field_pack; the FSM, registers, and counter SHALL be in jump_encoder.

Verification
REQ-027 SHALL cover: target 0x0040_0020, pc_plus4 0x0040_0004, link=0 -> next cycle out_valid=1, instr 0x0810_0008, no errors.
REQ-028 SHALL cover: same inputs with link=1 -> instr 0x0C10_0008.
REQ-029 SHALL cover: target 0x0040_0022 -> instr 0x0810_0008, err_align=1, err_count increments to 1.
REQ-030 SHALL cover: target 0x1000_0000, pc_plus4 0x0040_0004 -> instr 0x0800_0000, err_region=1.
REQ-031 SHALL cover: out_ready=0 for 3 cycles with in_valid held -> in_ready=0 and instr stable; then out_ready=1 -> swap in the same cycle, no request lost or duplicated.
REQ-032 SHALL cover: 260 erroneous requests -> err_count saturates at 0xFF; reset asserted while FULL -> out_valid=0 and err_count=0 immediately.
